router_sync_n: RTL and testbench

//  Parametrised channel synchroniser for the N-output router. Sits between the router FSM and NUM_CH output FIFOs.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_sync_wdog.sv | 57 +++++
 rtl/router_sync_n.sv | 81 ++++++++
 tb/tb_router_sync_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router synchroniser.
package router_pkg;

  localparam int ROUTER_TIMEOUT_DEF = 30;
  localparam int ROUTER_MAX_CH      = 16;

  // Out-of-range addresses decode to all zeros.
  function automatic logic [ROUTER_MAX_CH-1:0] onehot(input int unsigned addr);
    logic [ROUTER_MAX_CH-1:0] v;
    v = '0;
    for (int i = 0; i < ROUTER_MAX_CH; i++)
      if (addr == i) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Single-channel read-timeout watchdog: counter, soft_reset pulse, sticky status.
// ROUTER_SYNC_TO_CNT_EN adds a saturating timeout-event counter.
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             empty,
  input  logic             read_enb,
  input  logic             sts_clr,
`ifdef ROUTER_SYNC_TO_CNT_EN
  output logic [CNT_W-1:0] to_cnt,
`endif
  output logic             soft_reset,
  output logic             timeout_sts
);

  localparam logic [TO_W-1:0] RELOAD = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt;
  logic            fire;

  // Empty and read both mean nothing is stuck, so both restart the count.
  assign fire = !empty && !read_enb && (cnt == TO_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= RELOAD;
      soft_reset <= 1'b0;
    end else if (empty || read_enb || fire) begin
      cnt        <= RELOAD;
      soft_reset <= fire;
    end else begin
      cnt        <= cnt - TO_W'(1);
      soft_reset <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)        timeout_sts <= 1'b0;
    else if (fire)    timeout_sts <= 1'b1;
    else if (sts_clr) timeout_sts <= 1'b0;
  end

`ifdef ROUTER_SYNC_TO_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)                    to_cnt <= '0;
    else if (sts_clr)             to_cnt <= fire ? CNT_W'(1) : '0;
    else if (fire && !(&to_cnt))  to_cnt <= to_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/router_sync_n.sv
// Router channel synchroniser: destination latch, write steering, full mux,
// per-channel watchdogs. ROUTER_SYNC_TO_CNT_EN enables the to_cnt port.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    detect_add,
  input  logic [ADDR_W-1:0]       data_in,
  input  logic                    write_enb_reg,
  input  logic [NUM_CH-1:0]       read_enb,
  input  logic [NUM_CH-1:0]       empty,
  input  logic [NUM_CH-1:0]       full,
  input  logic [NUM_CH-1:0]       sts_clr,
  output logic [NUM_CH-1:0]       write_enb,
  output logic                    fifo_full,
  output logic [NUM_CH-1:0]       vld_out,
  output logic [NUM_CH-1:0]       soft_reset,
  output logic                    addr_err,
`ifdef ROUTER_SYNC_TO_CNT_EN
  output logic [NUM_CH*CNT_W-1:0] to_cnt,
`endif
  output logic [NUM_CH-1:0]       timeout_sts
);

  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

  logic [ADDR_W-1:0]        dest;
  logic [ROUTER_MAX_CH-1:0] dest_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      dest     <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      dest     <= data_in;
      addr_err <= ({1'b0, data_in} >= NUM_CH_L);
    end
  end

  assign dest_oh = onehot(32'(dest));

  // Illegal destinations never write and never stall, so the packet drains.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (!addr_err) begin
      if (write_enb_reg) write_enb = dest_oh[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (dest_oh[i]) fifo_full = full[i];
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    router_sync_wdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W),
      .CNT_W   (CNT_W)
    ) u_wdog (
      .clock       (clock),
      .reset       (reset),
      .empty       (empty[g]),
      .read_enb    (read_enb[g]),
      .sts_clr     (sts_clr[g]),
`ifdef ROUTER_SYNC_TO_CNT_EN
      .to_cnt      (to_cnt[g*CNT_W +: CNT_W]),
`endif
      .soft_reset  (soft_reset[g]),
      .timeout_sts (timeout_sts[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (NUM_CH=3, TIMEOUT=30, CNT_W=2).
module tb_router_sync_n;

  localparam int NCH = 3;
  localparam int CW  = 2;

  logic            clock = 1'b0;
  logic            reset, detect_add, write_enb_reg;
  logic [1:0]      data_in;
  logic [NCH-1:0]  read_enb, empty, full, sts_clr;
  logic [NCH-1:0]  write_enb, vld_out, soft_reset, timeout_sts;
  logic            fifo_full, addr_err;
`ifdef ROUTER_SYNC_TO_CNT_EN
  logic [NCH*CW-1:0] to_cnt;
`endif

  int checks = 0;
  int errors = 0;

  router_sync_n #(.NUM_CH(NCH), .ADDR_W(2), .TIMEOUT(30), .TO_W(5), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .sts_clr(sts_clr), .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err),
`ifdef ROUTER_SYNC_TO_CNT_EN
    .to_cnt(to_cnt),
`endif
    .timeout_sts(timeout_sts));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // n edges of channel ch valid and unread, expecting no pulse on any of them
  task automatic idle_edges(input int ch, input int n, input string name);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (soft_reset[ch]) bad++;
    end
    chk(name, bad, 0);
  endtask

  typedef struct {
    logic [1:0] data;
    logic       wer;
    logic [2:0] full;
    logic [2:0] we;
    logic       ff;
    logic       ae;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'd2, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{2'd0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 1'b1, 3'b101, 3'b010, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 1'b1, 3'b111, 3'b000, 1'b0, 1'b1};
    vecs[5] = '{2'd1, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0};
    vecs[6] = '{2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0};

    reset = 1'b1; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    read_enb = '0; empty = 3'b101; full = '0; sts_clr = '0;

    // reset held two edges
    step(); step();
    chk("rst_write_enb", write_enb, 3'b000);
    chk("rst_soft_reset", soft_reset, 3'b000);
    chk("rst_timeout_sts", timeout_sts, 3'b000);
    chk("rst_vld_out", vld_out, 3'b010);
    chk("rst_addr_err", addr_err, 1'b0);
    full = 3'b001; #1;
    chk("rst_fifo_full", fifo_full, 1'b1);
    write_enb_reg = 1'b1; #1;
    chk("rst_write_enb_dest0", write_enb, 3'b001);
    write_enb_reg = 1'b0; full = '0;
    reset = 1'b0; empty = 3'b111;
    step();

    // header latch then steered write/full
    for (int i = 0; i < 7; i++) begin
      detect_add = 1'b1; data_in = vecs[i].data;
      step();
      detect_add = 1'b0; write_enb_reg = vecs[i].wer; full = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_write_enb", i), write_enb, vecs[i].we);
      chk($sformatf("vec%0d_fifo_full", i), fifo_full, vecs[i].ff);
      chk($sformatf("vec%0d_addr_err", i), addr_err, vecs[i].ae);
    end

    // write during detect_add cycle still targets the old destination (dest=0)
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b1; #1;
    chk("detect_cycle_old_dest", write_enb, 3'b001);
    step();
    detect_add = 1'b0; #1;
    chk("detect_cycle_new_dest", write_enb, 3'b100);
    write_enb_reg = 1'b0; full = '0;

    // vld_out follows empty
    empty = 3'b010; #1;
    chk("vld_out_pattern", vld_out, 3'b101);
    empty = 3'b111; step();

    // ch0 timeout on edge 30
    empty[0] = 1'b0;
    idle_edges(0, 29, "wd0_no_early_pulse");
    step();
    chk("wd0_pulse_edge30", soft_reset, 3'b001);
    chk("wd0_sts_set", timeout_sts, 3'b001);
    step();
    chk("wd0_pulse_one_cycle", soft_reset[0], 1'b0);

    // read on the would-be pulse edge suppresses it
    empty[0] = 1'b1; step(); empty[0] = 1'b0;
    idle_edges(0, 29, "wd0b_no_early_pulse");
    read_enb[0] = 1'b1;
    step();
    read_enb[0] = 1'b0;
    chk("wd0_read_wins", soft_reset[0], 1'b0);
    sts_clr[0] = 1'b1; step(); sts_clr[0] = 1'b0;
    chk("wd0_sts_clr", timeout_sts[0], 1'b0);
    empty[0] = 1'b1; step();

    // ch1: pulse and clear on the same edge, set wins; then clear alone
    empty[1] = 1'b0;
    idle_edges(1, 29, "wd1_no_early_pulse");
    sts_clr[1] = 1'b1;
    step();
    chk("wd1_pulse", soft_reset[1], 1'b1);
    chk("wd1_set_wins", timeout_sts[1], 1'b1);
    empty[1] = 1'b1;
    step();
    sts_clr[1] = 1'b0;
    chk("wd1_clr_alone", timeout_sts[1], 1'b0);

    // reset mid-count discards the in-flight count
    empty[2] = 1'b0;
    idle_edges(2, 10, "wd2_pre_reset");
    reset = 1'b1; step(); reset = 1'b0;
    chk("wd2_reset_sts", timeout_sts, 3'b000);
    idle_edges(2, 29, "wd2_restart_no_early");
    step();
    chk("wd2_pulse_after_restart", soft_reset[2], 1'b1);
    empty[2] = 1'b1; sts_clr[2] = 1'b1; step(); sts_clr[2] = 1'b0;

`ifdef ROUTER_SYNC_TO_CNT_EN
    // four ch0 timeouts saturate the 2-bit counter
    chk("tocnt_start", to_cnt, 6'd0);
    empty[0] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      idle_edges(0, 29, "tocnt_gap");
      step();
    end
    chk("tocnt_two", to_cnt[1:0], 2'd2);
    for (int p = 0; p < 2; p++) begin
      idle_edges(0, 29, "tocnt_gap");
      step();
    end
    chk("tocnt_saturated", to_cnt[1:0], 2'd3);
    empty[0] = 1'b1; sts_clr[0] = 1'b1; step(); sts_clr[0] = 1'b0;
    chk("tocnt_cleared", to_cnt[1:0], 2'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
